ahb_irq_ctrl: RTL

AHB_IRQ_CTRL -- requirements
Module: ahb_irq_ctrl

---
 rtl/ahb_irq_pkg.sv | 47 ++++
 rtl/irq_prio_enc.sv | 33 +++
 rtl/ahb_irq_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ahb_irq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package     : ahb_irq_pkg
// Description : Shared constants and types for the AHB-Lite interrupt
//               controller: source count default, interrupt-ID width,
//               register offsets and the register-select decode helper.
// Revision    : 1.0  initial release
// ============================================================================
package ahb_irq_pkg;

    localparam int C_NSRC_DEFAULT = 8;
    localparam int C_ID_W         = 3;
    localparam int C_OFS_W        = 5;

    localparam logic [C_OFS_W-1:0] C_OFS_ENABLE   = 5'h00;
    localparam logic [C_OFS_W-1:0] C_OFS_PENDING  = 5'h04;
    localparam logic [C_OFS_W-1:0] C_OFS_CLEAR    = 5'h08;
    localparam logic [C_OFS_W-1:0] C_OFS_CLAIM    = 5'h0C;
    localparam logic [C_OFS_W-1:0] C_OFS_COMPLETE = 5'h10;

    typedef enum logic [2:0] {
        REG_ENABLE   = 3'd0,
        REG_PENDING  = 3'd1,
        REG_CLEAR    = 3'd2,
        REG_CLAIM    = 3'd3,
        REG_COMPLETE = 3'd4,
        REG_NONE     = 3'd5
    } reg_sel_e;

    // Offsets must match exactly; anything else (including misaligned
    // offsets) selects nothing and reads as zero.
    function automatic reg_sel_e decode_ofs(input logic [C_OFS_W-1:0] ofs);
        reg_sel_e sel;
        case (ofs)
            C_OFS_ENABLE:   sel = REG_ENABLE;
            C_OFS_PENDING:  sel = REG_PENDING;
            C_OFS_CLEAR:    sel = REG_CLEAR;
            C_OFS_CLAIM:    sel = REG_CLAIM;
            C_OFS_COMPLETE: sel = REG_COMPLETE;
            default:        sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : irq_prio_enc
// Description : Combinational fixed-priority encoder. Bit 0 has the highest
//               priority.
// Ports       : i_req   [N-1:0]    request vector
//               o_valid             any request present
//               o_idx   [ID_W-1:0]  index of lowest set bit (0 when none)
// Revision    : 1.0  initial release
// ============================================================================
module irq_prio_enc #(
    parameter int N    = 8,
    parameter int ID_W = 3
) (
    input  logic [N-1:0]    i_req,
    output logic            o_valid,
    output logic [ID_W-1:0] o_idx
);

    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        // Scan from the top down so the lowest set index is written last.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = ID_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_irq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ahb_irq_ctrl
// Description : AHB-Lite slave interrupt controller with claim/complete
//               handshake, fixed priority (source 0 highest) and a single
//               non-nesting service slot.
// Build macro : IRQ_CTRL_EDGE_EN - when defined, sources are rising-edge
//               detected and pending bits are sticky (cleared by CLEAR writes
//               or claims); otherwise pending follows irq_src (level mode).
// Ports       : HCLK, HRESETn (async, active-low)
//               HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY  AHB-Lite inputs
//               HRDATA, HREADYOUT                           AHB-Lite outputs
//               irq_src [NSRC-1:0]  interrupt requests
//               irq_out             registered request to the CPU
//               irq_id  [2:0]       registered winning source index
// Registers   : 0x00 ENABLE RW, 0x04 PENDING RO, 0x08 CLEAR WO (W1C),
//               0x0C CLAIM RO, 0x10 COMPLETE WO
// Revision    : 1.0  initial release
// ============================================================================
module ahb_irq_ctrl
    import ahb_irq_pkg::*;
#(
    parameter int NSRC = C_NSRC_DEFAULT
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    input  logic [NSRC-1:0]   irq_src,
    output logic              irq_out,
    output logic [C_ID_W-1:0] irq_id
);

    // ------------------------------------------------------------------
    // Address phase capture
    // ------------------------------------------------------------------
    logic               r_hsel;
    logic               r_hwrite;
    logic               r_htrans1;
    logic [C_OFS_W-1:0] r_ofs;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_hsel    <= 1'b0;
            r_hwrite  <= 1'b0;
            r_htrans1 <= 1'b0;
            r_ofs     <= '0;
        end else if (HREADY) begin
            r_hsel    <= HSEL;
            r_hwrite  <= HWRITE;
            r_htrans1 <= HTRANS[1];
            r_ofs     <= HADDR[C_OFS_W-1:0];
        end
    end

    reg_sel_e w_sel;
    logic     w_wr_xfer;
    logic     w_rd_xfer;

    assign w_sel     = decode_ofs(r_ofs);
    assign w_wr_xfer = r_hsel & r_hwrite & r_htrans1;
    assign w_rd_xfer = r_hsel & ~r_hwrite & r_htrans1;
    assign HREADYOUT = 1'b1;

    // ------------------------------------------------------------------
    // Priority selection
    // ------------------------------------------------------------------
    logic [NSRC-1:0]   r_enable;
    logic [NSRC-1:0]   r_pending;
    logic [NSRC-1:0]   w_eligible;
    logic              w_any;
    logic [C_ID_W-1:0] w_winner;
    logic              w_claim_valid;

    assign w_eligible = r_pending & r_enable;

    irq_prio_enc #(
        .N    (NSRC),
        .ID_W (C_ID_W)
    ) u_prio (
        .i_req   (w_eligible),
        .o_valid (w_any),
        .o_idx   (w_winner)
    );

    // ------------------------------------------------------------------
    // Service state: a claim opens the slot, a matching complete closes it
    // ------------------------------------------------------------------
    logic              r_busy;
    logic [C_ID_W-1:0] r_in_service;
    logic              w_claim;
    logic              w_complete;

    assign w_claim_valid = w_any & ~r_busy;
    assign w_claim       = w_rd_xfer && (w_sel == REG_CLAIM) && w_claim_valid;
    assign w_complete    = w_wr_xfer && (w_sel == REG_COMPLETE) && r_busy &&
                           (HWDATA[C_ID_W-1:0] == r_in_service);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_busy       <= 1'b0;
            r_in_service <= '0;
        end else if (w_claim) begin
            r_busy       <= 1'b1;
            r_in_service <= w_winner;
        end else if (w_complete) begin
            r_busy       <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_enable <= '0;
        end else if (w_wr_xfer && (w_sel == REG_ENABLE)) begin
            r_enable <= HWDATA[NSRC-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Pending tracking
    // ------------------------------------------------------------------
`ifdef IRQ_CTRL_EDGE_EN
    logic [NSRC-1:0] r_src_q;
    logic [NSRC-1:0] w_set;
    logic [NSRC-1:0] w_clr;

    assign w_set = irq_src & ~r_src_q;
    assign w_clr = ((w_wr_xfer && (w_sel == REG_CLEAR)) ? HWDATA[NSRC-1:0] : '0) |
                   (w_claim ? (NSRC'(1) << w_winner) : '0);

    // Set is OR-ed in after the clear so a coincident new edge survives.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_src_q   <= '0;
            r_pending <= '0;
        end else begin
            r_src_q   <= irq_src;
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end
`else
    // Level mode: the peripheral owns the request; CLEAR and claims only
    // affect the controller's service state, never the pending image.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_pending <= '0;
        end else begin
            r_pending <= irq_src;
        end
    end
`endif

    // ------------------------------------------------------------------
    // CPU request outputs
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq_out <= 1'b0;
            irq_id  <= '0;
        end else begin
            irq_out <= w_claim_valid;
            irq_id  <= w_winner;
        end
    end

    // ------------------------------------------------------------------
    // Read data
    // ------------------------------------------------------------------
    always_comb begin
        HRDATA = '0;
        case (w_sel)
            REG_ENABLE:  HRDATA[NSRC-1:0]   = r_enable;
            REG_PENDING: HRDATA[NSRC-1:0]   = r_pending;
            REG_CLAIM: begin
                HRDATA[31]           = w_claim_valid;
                HRDATA[C_ID_W-1:0]   = w_winner;
            end
            default:     HRDATA = '0;
        endcase
    end

    // Address bits above the register window, the sequential/nonseq
    // distinction and write-data bits beyond the source count carry no
    // meaning for this block.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, HADDR[31:C_OFS_W], HTRANS[0], HWDATA[31:NSRC]};

endmodule
`default_nettype wire
